// File: rtl/tl_pkg.sv
// Shared TileLink definitions used by hosts and devices on the interconnect.
// Contents:
//   tl_a_op_e - A-channel opcodes (Get, PutFullData, ...)
//   tl_d_op_e - D-channel opcodes (AccessAck, AccessAckData, ...)
package tl_pkg;

  typedef enum logic [2:0] {
    PUT_FULL_DATA    = 3'h0,
    PUT_PARTIAL_DATA = 3'h1,
    ARITHMETIC_DATA  = 3'h2,
    LOGICAL_DATA     = 3'h3,
    GET              = 3'h4,
    INTENT           = 3'h5
  } tl_a_op_e;

  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'h0,
    ACCESS_ACK_DATA = 3'h1,
    HINT_ACK        = 3'h2
  } tl_d_op_e;

endpackage

// File: rtl/tl_copy_engine.sv
// TileLink-UL host that copies len_i full-width beats from src_i to dst_i.
// Each beat is a Get followed by a PutFullData; one transaction in flight.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               one-cycle start request, honoured only in IDLE
//   src_i, dst_i, len_i   copy parameters; addresses are beat-aligned on capture
//   busy_o                copy in progress (not IDLE, not FIN)
//   done_o                one-cycle pulse as a copy ends (success or abort)
//   error_o               last copy aborted; cleared by the next accepted start
//   host_a_*              A channel (outputs except host_a_ready)
//   host_d_*              D channel (inputs except host_d_ready)
//   dbg_state_o           current FSM state encoding, for observation only
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. Once valid is raised it stays high, with its payload unchanged, until
// that edge; ready may be raised or lowered at any time.
//
// All outputs are decoded from the state register and datapath registers, so
// nothing combinational runs from an input to an output.
module tl_copy_engine
  import tl_pkg::*;
#(
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned AddrWidth   = 38,
  parameter int unsigned SourceWidth = 3,
  parameter int unsigned SinkWidth   = 1,
  parameter int unsigned SourceId    = 0,
  parameter int unsigned LenWidth    = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [AddrWidth-1:0]     src_i,
  input  logic [AddrWidth-1:0]     dst_i,
  input  logic [LenWidth-1:0]      len_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic                     host_a_valid,
  input  logic                     host_a_ready,
  output logic [2:0]               host_a_opcode,
  output logic [2:0]               host_a_param,
  output logic [1:0]               host_a_size,
  output logic [SourceWidth-1:0]   host_a_source,
  output logic [AddrWidth-1:0]     host_a_address,
  output logic [DataWidth/8-1:0]   host_a_mask,
  output logic                     host_a_corrupt,
  output logic [DataWidth-1:0]     host_a_data,
  input  logic                     host_d_valid,
  output logic                     host_d_ready,
  input  logic [2:0]               host_d_opcode,
  input  logic [1:0]               host_d_param,
  input  logic [1:0]               host_d_size,
  input  logic [SourceWidth-1:0]   host_d_source,
  input  logic [SinkWidth-1:0]     host_d_sink,
  input  logic                     host_d_denied,
  input  logic                     host_d_corrupt,
  input  logic [DataWidth-1:0]     host_d_data,
  output logic [2:0]               dbg_state_o
);

  localparam int unsigned BeatBytes = DataWidth / 8;
  localparam int unsigned OffWidth  = $clog2(BeatBytes);
  // The size field is two bits wide, which covers beats up to 64 bits.
  localparam logic [1:0]           BeatSize   = 2'(OffWidth);
  localparam logic [AddrWidth-1:0] BeatStride = AddrWidth'(BeatBytes);
  localparam logic [AddrWidth-1:0] AlignMask  = ~AddrWidth'(BeatBytes - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_FIN     = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   src_q, dst_q;
  logic [LenWidth-1:0]    rem_q;
  logic [DataWidth-1:0]   beat_q;
  logic                   error_q;

  logic rd_ok, wr_ok;
  assign rd_ok = (host_d_opcode == ACCESS_ACK_DATA) && !host_d_denied && !host_d_corrupt;
  assign wr_ok = (host_d_opcode == ACCESS_ACK) && !host_d_denied;

  // D-channel routing fields are not needed with a single outstanding request.
  logic unused_d;
  assign unused_d = ^{host_d_param, host_d_size, host_d_source, host_d_sink};

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. In the RESP states d_ready is high, so d_valid alone
  // marks an accepted D beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = (len_i == '0) ? ST_FIN : ST_RD_REQ;
      end
      ST_RD_REQ: begin
        if (host_a_ready) state_d = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (host_d_valid) state_d = rd_ok ? ST_WR_REQ : ST_FIN;
      end
      ST_WR_REQ: begin
        if (host_a_ready) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (host_d_valid) begin
          if (!wr_ok)                         state_d = ST_FIN;
          else if (rem_q == LenWidth'(1))     state_d = ST_FIN;
          else                                state_d = ST_RD_REQ;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: addresses, remaining count, beat buffer and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            src_q   <= src_i & AlignMask;
            dst_q   <= dst_i & AlignMask;
            rem_q   <= len_i;
            error_q <= 1'b0;
          end
        end
        ST_RD_RESP: begin
          if (host_d_valid) begin
            beat_q <= host_d_data;
            if (!rd_ok) error_q <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (host_d_valid) begin
            if (wr_ok) begin
              // Address arithmetic wraps modulo 2^AddrWidth by width truncation.
              src_q <= src_q + BeatStride;
              dst_q <= dst_q + BeatStride;
              rem_q <= rem_q - LenWidth'(1);
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode. Payload is zero whenever no request is being offered.
  always_comb begin
    host_a_valid   = 1'b0;
    host_a_opcode  = '0;
    host_a_param   = '0;
    host_a_size    = '0;
    host_a_source  = '0;
    host_a_address = '0;
    host_a_mask    = '0;
    host_a_corrupt = 1'b0;
    host_a_data    = '0;
    case (state_q)
      ST_RD_REQ: begin
        host_a_valid   = 1'b1;
        host_a_opcode  = GET;
        host_a_size    = BeatSize;
        host_a_source  = SourceWidth'(SourceId);
        host_a_address = src_q;
        host_a_mask    = '1;
      end
      ST_WR_REQ: begin
        host_a_valid   = 1'b1;
        host_a_opcode  = PUT_FULL_DATA;
        host_a_size    = BeatSize;
        host_a_source  = SourceWidth'(SourceId);
        host_a_address = dst_q;
        host_a_mask    = '1;
        host_a_data    = beat_q;
      end
      default: ;
    endcase
  end

  assign host_d_ready = (state_q == ST_RD_RESP) || (state_q == ST_WR_RESP);
  assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done_o       = (state_q == ST_FIN);
  assign error_o      = error_q;
  assign dbg_state_o  = state_q;

endmodule
